// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: player-input front end for the snake game.
//   Syncs and debounces four direction buttons, rejects illegal turns, and
//   emits the one-hot direction and the periodic move tick.
//   i_Clk, i_Rst_n            clock, async active-low reset
//   i_Btn[3:0]                raw buttons {DOWN, UP, LEFT, RIGHT}, 1 = pressed
//   i_Enable, i_Kill          game enable and kill levels
//   o_Direction[3:0]          one-hot direction, 0000 = still
//   o_SnakeTick               one-cycle move strobe
//   o_Pending                 a turn is queued for the next tick
module snake_input_ctrl #(
  parameter int unsigned c_DEBOUNCE_CYCLES = 250000,
  parameter int unsigned c_DEBOUNCE_W      = 18,
  parameter int unsigned c_TICK_CYCLES     = 6250000,
  parameter int unsigned c_TICK_W          = 23
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [3:0] i_Btn,
  input  logic       i_Enable,
  input  logic       i_Kill,
  output logic [3:0] o_Direction,
  output logic       o_SnakeTick,
  output logic       o_Pending
);
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
  logic [1:0] rst_sync_q, rst_sync_d;
  logic rst_n;
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
  logic [c_DEBOUNCE_W-1:0] db_cnt_q [4];
  logic [c_DEBOUNCE_W-1:0] db_cnt_d [4];
  state_t state_q, state_d;
  logic [c_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0] dir_q, dir_d, pend_dir_q, pend_dir_d, press, sel, opp;
  logic pend_q, pend_d, tick_q, tick_d, wrap, accept;
  // Reset asserts asynchronously but is released on a clock edge.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) rst_sync_q <= '0;
    else rst_sync_q <= rst_sync_d;
  assign rst_n = rst_sync_q[1];
  always_comb begin
    sync1_d = i_Btn;
    sync2_d = sync1_q;
    for (int b = 0; b < 4; b++) begin
      stable_d[b] = stable_q[b];
      db_cnt_d[b] = '0;
      if (sync2_q[b] != stable_q[b]) begin
        if (db_cnt_q[b] == c_DEBOUNCE_W'(c_DEBOUNCE_CYCLES - 1)) stable_d[b] = ~stable_q[b];
        else db_cnt_d[b] = db_cnt_q[b] + 1'b1;
      end
    end
  end
  // Press pulse is the cycle whose edge raises the stable level; releases are ignored.
  assign press = stable_d & ~stable_q;
  assign sel = press[0] ? 4'b0001 : press[1] ? 4'b0010 : press[2] ? 4'b0100 : press[3] ? 4'b1000 : 4'b0000;
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    dir_d      = dir_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    tick_d     = 1'b0;
    opp        = 4'b0000;
    accept     = 1'b0;
    wrap       = tick_cnt_q == c_TICK_W'(c_TICK_CYCLES - 1);
    case (state_q)
      IDLE: if (i_Enable && sel != 4'b0000) begin
        dir_d      = sel;
        tick_cnt_d = '0;
        state_d    = RUN;
      end
      RUN: if (i_Kill || !i_Enable) begin
        state_d    = i_Kill ? DEAD : IDLE;
        dir_d      = 4'b0000;
        pend_d     = 1'b0;
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = wrap ? '0 : tick_cnt_q + 1'b1;
        if (wrap) begin
          tick_d = 1'b1;
          pend_d = 1'b0;
          if (pend_q) dir_d = pend_dir_q;
        end
        // Judge the press against the direction visible after this edge.
        opp    = {dir_d[2], dir_d[3], dir_d[0], dir_d[1]};
        accept = sel != 4'b0000 && sel != dir_d && sel != opp;
        if (accept) begin
          pend_d     = 1'b1;
          pend_dir_d = sel;
        end
      end
      DEAD: begin
        dir_d  = 4'b0000;
        pend_d = 1'b0;
        if (!i_Enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_Clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int b = 0; b < 4; b++) db_cnt_q[b] <= '0;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      dir_q      <= '0;
      pend_dir_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      for (int b = 0; b < 4; b++) db_cnt_q[b] <= db_cnt_d[b];
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      dir_q      <= dir_d;
      pend_dir_q <= pend_dir_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
    end
  assign o_Direction = dir_q;
  assign o_SnakeTick = tick_q;
  assign o_Pending   = pend_q;
endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb_snake_input_ctrl: directed vector bench for snake_input_ctrl.
module tb_snake_input_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] btn;
  logic en, kill;
  logic [3:0] dir;
  logic tick, pend;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [3:0] btn;
    logic en;
    logic kill;
    int n;
    logic [3:0] dir;
    logic tick;
    logic pend;
  } vec_t;
  vec_t v[$];
  snake_input_ctrl #(
    .c_DEBOUNCE_CYCLES(4),
    .c_DEBOUNCE_W(3),
    .c_TICK_CYCLES(16),
    .c_TICK_W(4)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Btn(btn),
    .i_Enable(en),
    .i_Kill(kill),
    .o_Direction(dir),
    .o_SnakeTick(tick),
    .o_Pending(pend)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic chk_all(input string name, input logic [3:0] d, input logic t, input logic p);
    chk({name, " dir"}, dir, d);
    chk({name, " tick"}, {3'b0, tick}, {3'b0, t});
    chk({name, " pend"}, {3'b0, pend}, {3'b0, p});
  endtask
  initial begin
    int ticks;
    // Start RIGHT, ticks every 16, LEFT rejected, UP queued, UP->DOWN overwrite,
    // kill/dead, disable, glitch, simultaneous RIGHT+LEFT.
    v.push_back('{4'b0001, 1'b1, 1'b0, 5,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0001, 1'b1, 1'b0, 1,  4'b0001, 1'b0, 1'b0});
    v.push_back('{4'b0001, 1'b1, 1'b0, 15, 4'b0001, 1'b0, 1'b0});
    v.push_back('{4'b0001, 1'b1, 1'b0, 1,  4'b0001, 1'b1, 1'b0});
    v.push_back('{4'b0001, 1'b1, 1'b0, 1,  4'b0001, 1'b0, 1'b0});
    v.push_back('{4'b0001, 1'b1, 1'b0, 15, 4'b0001, 1'b1, 1'b0});
    v.push_back('{4'b0000, 1'b1, 1'b0, 8,  4'b0001, 1'b0, 1'b0});
    v.push_back('{4'b0010, 1'b1, 1'b0, 6,  4'b0001, 1'b0, 1'b0});
    v.push_back('{4'b0010, 1'b1, 1'b0, 2,  4'b0001, 1'b1, 1'b0});
    v.push_back('{4'b0100, 1'b1, 1'b0, 6,  4'b0001, 1'b0, 1'b1});
    v.push_back('{4'b0100, 1'b1, 1'b0, 9,  4'b0001, 1'b0, 1'b1});
    v.push_back('{4'b0100, 1'b1, 1'b0, 1,  4'b0100, 1'b1, 1'b0});
    v.push_back('{4'b0000, 1'b1, 1'b0, 7,  4'b0100, 1'b0, 1'b0});
    v.push_back('{4'b0001, 1'b1, 1'b0, 6,  4'b0100, 1'b0, 1'b1});
    v.push_back('{4'b0001, 1'b1, 1'b0, 3,  4'b0001, 1'b1, 1'b0});
    v.push_back('{4'b0100, 1'b1, 1'b0, 6,  4'b0001, 1'b0, 1'b1});
    v.push_back('{4'b1000, 1'b1, 1'b0, 6,  4'b0001, 1'b0, 1'b1});
    v.push_back('{4'b1000, 1'b1, 1'b0, 4,  4'b1000, 1'b1, 1'b0});
    v.push_back('{4'b0000, 1'b1, 1'b0, 6,  4'b1000, 1'b0, 1'b0});
    v.push_back('{4'b0000, 1'b1, 1'b1, 1,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0000, 1'b1, 1'b1, 9,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0001, 1'b1, 1'b1, 6,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0000, 1'b1, 1'b1, 6,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0000, 1'b0, 1'b0, 2,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0001, 1'b0, 1'b0, 6,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0000, 1'b0, 1'b0, 7,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0100, 1'b1, 1'b0, 3,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0011, 1'b1, 1'b0, 5,  4'b0000, 1'b0, 1'b0});
    v.push_back('{4'b0011, 1'b1, 1'b0, 1,  4'b0001, 1'b0, 1'b0});
    v.push_back('{4'b0011, 1'b1, 1'b0, 16, 4'b0001, 1'b1, 1'b0});
    rst_n = 1'b0;
    btn = 4'b0000;
    en = 1'b0;
    kill = 1'b0;
    step(3);
    chk_all("reset", 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(3);
    for (int i = 0; i < v.size(); i++) begin
      btn = v[i].btn;
      en = v[i].en;
      kill = v[i].kill;
      step(v[i].n);
      chk_all($sformatf("vec%0d", i), v[i].dir, v[i].tick, v[i].pend);
    end
    // Queue a turn, then assert reset mid-interval.
    btn = 4'b0000;
    step(7);
    btn = 4'b0100;
    step(6);
    chk_all("prereset", 4'b0001, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    btn = 4'b0000;
    #1;
    chk_all("async_rst", 4'b0000, 1'b0, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(4);
    chk_all("post_rst", 4'b0000, 1'b0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (tick) ticks++;
    end
    chk("idle_ticks", ticks[3:0], 4'd0);
    chk_all("idle_still", 4'b0000, 1'b0, 1'b0);
    btn = 4'b1000;
    step(5);
    chk_all("restart_pre", 4'b0000, 1'b0, 1'b0);
    step(1);
    chk_all("restart", 4'b1000, 1'b0, 1'b0);
    step(15);
    chk_all("restart_t15", 4'b1000, 1'b0, 1'b0);
    step(1);
    chk_all("restart_tick", 4'b1000, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
